// File: rtl/aes_round_engine_if.sv
// Request/response bundle between the key-expansion side and the AES round engine.
interface aes_round_engine_if #(
    parameter int RK_W = 1408
);
    logic             start;
    logic [127:0]     plaintext;
    logic [RK_W-1:0]  round_keys;
    logic             keys_valid;
    logic [127:0]     ciphertext;
    logic             done;
    logic             busy;

    modport master (
        output start, plaintext, round_keys, keys_valid,
        input  ciphertext, done, busy
    );

    modport slave (
        input  start, plaintext, round_keys, keys_valid,
        output ciphertext, done, busy
    );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: one full round per clock through 16 shared S-boxes,
// round keys taken from a pre-expanded 1408-bit bundle.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = TABLE[a];
endmodule

module aes_round_engine #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_engine_if.slave bus
);
    localparam int         RK_W = 128 * (NR + 1);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, WAIT_KEYS, ROUND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] s_q, s_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic [127:0] sb, sr, mc, rk0, rk_cur, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    for (genvar k = 0; k < 16; k++) begin : g_sub
        aes_sbox u_sbox (
            .a(s_q[127-8*k -: 8]),
            .y(sb[127-8*k -: 8])
        );
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign rk0 = bus.round_keys[RK_W-1 -: 128];

    always_comb begin
        rk_cur = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_q == 4'(i)) begin
                rk_cur = bus.round_keys[RK_W-1-128*i -: 128];
            end
        end
    end

    // Final round omits MixColumns.
    assign round_out = ((round_q == LAST) ? sr : mc) ^ rk_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            s_q     <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            s_q     <= s_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        s_d     = s_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pt_d   = bus.plaintext;
                    busy_d = 1'b1;
                    if (bus.keys_valid) begin
                        s_d     = bus.plaintext ^ rk0;
                        round_d = 4'd1;
                        state_d = ROUND;
                    end else begin
                        state_d = WAIT_KEYS;
                    end
                end
            end
            WAIT_KEYS: begin
                if (bus.keys_valid) begin
                    s_d     = pt_q ^ rk0;
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (round_q == 4'd0 || round_q > LAST) begin
                    round_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (round_q == LAST) begin
                    s_d     = round_out;
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    round_d = '0;
                    state_d = DONE;
                end else begin
                    s_d     = round_out;
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                round_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ciphertext = ct_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine: FIPS-197 vectors, key-wait, back-to-back, abort and ignored-start cases.
module tb_aes_round_engine;
    logic clk;
    logic rst;

    aes_round_engine_if bus ();

    aes_round_engine dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = 0;
    logic [127:0] exp_q[$];
    logic [7:0] tsbox [256];
    logic [1407:0] rk_b, rk_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inversion plus affine map, independent of the RTL table.
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [1407:0] bundle;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tsbox[t[23:16]], tsbox[t[15:8]], tsbox[t[7:0]], tsbox[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) bundle[1407-32*i -: 32] = w[i];
        return bundle;
    endfunction

    // Monitor: every done pulse pops one expected ciphertext.
    initial begin
        logic prev_done = 1'b0;
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("done_width", {127'd0, prev_done}, 128'd0);
                check("busy_at_done", {127'd0, bus.busy}, 128'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got ciphertext %h, required no done pulse (cycle %0d)", bus.ciphertext, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ciphertext", bus.ciphertext, e);
                end
                done_count++;
                last_done_cyc = cyc;
            end
            prev_done = bus.done;
        end
    end

    task automatic issue(input logic [127:0] pt, input logic [127:0] ct, output int e0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.plaintext = pt;
        exp_q.push_back(ct);
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int lat, input string name);
        int n0 = done_count;
        int t = 0;
        while (done_count == n0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_count == n0) begin
            tests++;
            fails++;
            $display("FAIL %s: no done within %0d cycles, required done after %0d", name, t, lat);
        end else begin
            check(name, 128'(last_done_cyc - base), 128'(lat));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int kv;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.plaintext = '0;
        bus.round_keys = '0;
        bus.keys_valid = 1'b0;
        init_sbox();
        rk_b = expand(KEY_B);
        rk_c = expand(KEY_C);

        #12;
        check("reset_busy", {127'd0, bus.busy}, 128'd0);
        check("reset_done", {127'd0, bus.done}, 128'd0);
        check("reset_ciphertext", bus.ciphertext, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.round_keys = rk_b;
        bus.keys_valid = 1'b1;

        // App.B vector, latency from start edge
        issue(PT_B, CT_B, e0);
        check("busy_after_start", {127'd0, bus.busy}, 128'd1);
        wait_done(e0, 10, "latency_app_b");

        // App.C.1 vector
        repeat (3) @(posedge clk);
        #1;
        bus.round_keys = rk_c;
        issue(PT_C, CT_C, e0);
        wait_done(e0, 10, "latency_app_c");

        // start before keys are ready
        repeat (3) @(posedge clk);
        #1;
        bus.round_keys = rk_b;
        bus.keys_valid = 1'b0;
        issue(PT_B, CT_B, e0);
        repeat (5) @(posedge clk);
        #1;
        check("wait_keys_busy", {127'd0, bus.busy}, 128'd1);
        check("wait_keys_no_done", 128'(done_count), 128'd2);
        bus.keys_valid = 1'b1;
        @(posedge clk);
        #1;
        kv = cyc;
        wait_done(kv, 10, "latency_after_keys");

        // start held high: two blocks, 12 cycles apart
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.plaintext = PT_B;
        exp_q.push_back(CT_B);
        exp_q.push_back(CT_B);
        @(posedge clk);
        #1;
        e0 = cyc;
        wait_done(e0, 10, "held_first_done");
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("held_second_accept", {127'd0, bus.busy}, 128'd1);
        wait_done(e0, 22, "held_done_spacing");

        // abort at round 5
        repeat (3) @(posedge clk);
        #1;
        issue(PT_B, CT_B, e0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("abort_busy", {127'd0, bus.busy}, 128'd0);
        check("abort_done", {127'd0, bus.done}, 128'd0);
        check("abort_ciphertext", bus.ciphertext, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_count), 128'd5);
        issue(PT_B, CT_B, e0);
        wait_done(e0, 10, "latency_after_abort");

        // start pulsed mid-round with other plaintext is ignored
        repeat (2) @(posedge clk);
        #1;
        issue(PT_B, CT_B, e0);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.plaintext = PT_C;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(e0, 10, "latency_ignore_start");
        repeat (20) @(posedge clk);
        #1;
        check("ciphertext_hold", bus.ciphertext, CT_B);
        check("idle_busy", {127'd0, bus.busy}, 128'd0);
        check("total_dones", 128'(done_count), 128'd7);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
